div_issue_queue: RTL and testbench
==================================

Name: div_issue_queue

Overview:
- Request front-end for the multi-cycle iterative divider.
- Buffers division requests, each carrying a tag, in a small FIFO. Issues one request at a time to the divider's data_valid_in / busy_out handshake, then catches the divider's result pulse and returns quotient, remainder and the original tag in order.
- Intercepts divide-by-zero locally, because the divider never raises its error output.

Parameters:
WIDTH, 64, operand/result width; must match the divider's WIDTH.
DEPTH, 4, request FIFO entries (power of two, >=2).
TAG_W, 4, request tag width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
req_valid_in  input  1  upstream request strobe
req_ready_out  output  1  FIFO can accept a request this cycle
req_dividend_in  input  WIDTH  request dividend
req_divisor_in  input  WIDTH  request divisor
req_tag_in  input  TAG_W  request tag
div_dividend_out  output  WIDTH  operand to divider
div_divisor_out  output  WIDTH  operand to divider
div_valid_out  output  1  one-cycle start pulse to divider
div_busy_in  input  1  divider busy
div_valid_in  input  1  divider result pulse
div_quotient_in  input  WIDTH  divider quotient
div_remainder_in  input  WIDTH  divider remainder
res_valid_out  output  1  one-cycle result pulse
res_quotient_out  output  WIDTH  result quotient
res_remainder_out  output  WIDTH  result remainder
res_tag_out  output  TAG_W  tag of the returned request
res_error_out  output  1  divisor was zero
count_out  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (asynchronous, rst_in high):
  - FIFO empty, count_out=0, req_ready_out=1.
  - div_valid_out=0, res_valid_out=0, res_error_out=0.
  - All data outputs =0; state=IDLE.
  - Reset mid-operation discards the queued request and any in-flight request. The divider shares rst_in.
- FIFO:
  - Push when req_valid_in && req_ready_out.
  - req_ready_out = (count_out != DEPTH), registered-state based only. A same-cycle pop does not free a slot for a push while full.
  - Simultaneous push and pop when not full: count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Strict FIFO order; no bypass, so a pushed entry is poppable at the earliest the following cycle.
- FSM states: IDLE, WAIT.
- IDLE:
  - Pops the head when count_out>0 and div_busy_in==0.
  - If head divisor==0: no issue. Next cycle res_valid_out=1 for 1 cycle with res_quotient_out={WIDTH{1'b1}}, res_remainder_out=head dividend, res_error_out=1, res_tag_out=head tag. Stay IDLE.
  - Else: register the operands onto div_dividend_out/div_divisor_out, set div_valid_out=1 for exactly 1 cycle, store the tag, go to WAIT.
- WAIT:
  - Remains until div_valid_in==1.
  - Next cycle: res_valid_out=1 for 1 cycle; res_quotient_out/res_remainder_out latch div_quotient_in/div_remainder_in; res_tag_out=stored tag; res_error_out=0. Return to IDLE.
  - No new issue while in WAIT.
- Latency:
  - Request pushed in cycle N reaches div_valid_out no earlier than N+2: visible N+1, issued N+2.
  - Divider takes about WIDTH/2 cycles.
  - Result appears 1 cycle after div_valid_in.
  - Back-to-back: the next pop may occur in the cycle res_valid_out is high.
- res_* data outputs hold their values between pulses; res_error_out holds until the next result.
- div_valid_in while IDLE: ignored, no result emitted.
- No result backpressure: the consumer must accept every res_valid_out pulse.
- div_dividend_out/div_divisor_out hold the last issued operands.

Test Plan:
- Push 100/7 tag 3 into an empty queue -> one div_valid_out pulse with 100,7. After the divider returns: res_valid_out pulse with q=14, r=2, tag=3, error=0.
- Push 55/0 tag 9 -> no div_valid_out; res_valid_out pulse with q=all-ones, r=55, tag=9, error=1, two cycles after the push.
- Push 5 requests back-to-back (tags 0-4) with DEPTH=4 while the first is in the divider -> req_ready_out low once count_out=4. The fifth is held until a pop; results return with tags 0,1,2,3,4 in order and correct quotients.
- Full queue, pop cycle coincides with req_valid_in -> push refused that cycle and accepted the next; count_out goes 4->3->4.
- Assert rst_in asynchronously mid-WAIT with 2 queued requests -> all outputs immediately 0, count_out=0, req_ready_out=1. No res_valid_out afterwards until new pushes.
- Spurious div_valid_in pulse while IDLE with an empty queue -> no res_valid_out, state stays IDLE.

Source files
------------

// File: rtl/div_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : div_issue_queue
//  Description : Request front-end for the multi-cycle iterative divider.
//                Tagged division requests are buffered in a small FIFO and
//                issued one at a time over the divider's start/busy
//                handshake. The divider's result pulse is then returned
//                together with the original tag, in request order.
//                Divide-by-zero is resolved locally without involving the
//                divider, because the divider never flags it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in            : system clock
//    rst_in            : asynchronous active-high reset (shared with divider)
//    req_valid_in      : upstream request strobe
//    req_ready_out     : FIFO can accept a request this cycle
//    req_dividend_in   : request dividend
//    req_divisor_in    : request divisor
//    req_tag_in        : request tag
//    div_dividend_out  : dividend presented to the divider (held)
//    div_divisor_out   : divisor presented to the divider (held)
//    div_valid_out     : one-cycle start pulse to the divider
//    div_busy_in       : divider busy
//    div_valid_in      : divider result pulse
//    div_quotient_in   : divider quotient
//    div_remainder_in  : divider remainder
//    res_valid_out     : one-cycle result pulse
//    res_quotient_out  : result quotient (held between pulses)
//    res_remainder_out : result remainder (held between pulses)
//    res_tag_out       : tag of the returned request (held)
//    res_error_out     : divisor was zero (held until next result)
//    count_out         : FIFO occupancy
// ============================================================================
module div_issue_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic [WIDTH-1:0]           req_dividend_in,
    input  logic [WIDTH-1:0]           req_divisor_in,
    input  logic [TAG_W-1:0]           req_tag_in,
    output logic [WIDTH-1:0]           div_dividend_out,
    output logic [WIDTH-1:0]           div_divisor_out,
    output logic                       div_valid_out,
    input  logic                       div_busy_in,
    input  logic                       div_valid_in,
    input  logic [WIDTH-1:0]           div_quotient_in,
    input  logic [WIDTH-1:0]           div_remainder_in,
    output logic                       res_valid_out,
    output logic [WIDTH-1:0]           res_quotient_out,
    output logic [WIDTH-1:0]           res_remainder_out,
    output logic [TAG_W-1:0]           res_tag_out,
    output logic                       res_error_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [WIDTH-1:0]   c_ALL_ONES  = {WIDTH{1'b1}};

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem_dividend [DEPTH];
    logic [WIDTH-1:0]   r_mem_divisor  [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag      [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;

    logic [TAG_W-1:0]   r_tag;        // tag of the request inside the divider

    logic               w_push;
    logic               w_pop;
    logic               w_issue;      // pop with a non-zero divisor
    logic               w_zero_res;   // pop with a zero divisor
    logic               w_div_res;    // divider result captured in WAIT

    logic [WIDTH-1:0]   w_head_dividend;
    logic [WIDTH-1:0]   w_head_divisor;
    logic [TAG_W-1:0]   w_head_tag;
    logic               w_head_zero;

    // Ready depends only on the registered count: a pop in the same cycle
    // does not open a slot for a push while the FIFO is full.
    assign req_ready_out = (r_count != c_CNT_FULL);
    assign w_push        = req_valid_in && req_ready_out;
    assign count_out     = r_count;

    // Head of the FIFO. Only written entries are ever read, because a pop
    // requires a non-zero registered count (no write-through bypass).
    assign w_head_dividend = r_mem_dividend[r_rd_ptr];
    assign w_head_divisor  = r_mem_divisor[r_rd_ptr];
    assign w_head_tag      = r_mem_tag[r_rd_ptr];
    assign w_head_zero     = (w_head_divisor == '0);

    // Storage array carries no reset: occupancy is tracked by the pointers
    // and the count, so stale contents are never observed.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_dividend[r_wr_ptr] <= req_dividend_in;
            r_mem_divisor[r_wr_ptr]  <= req_divisor_in;
            r_mem_tag[r_wr_ptr]      <= req_tag_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_ST_IDLE: begin
                // Zero-divisor pops are answered locally and stay in IDLE.
                if (w_issue) begin
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (div_valid_in) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_pop      = 1'b0;
        w_issue    = 1'b0;
        w_zero_res = 1'b0;
        w_div_res  = 1'b0;
        unique case (r_state)
            c_ST_IDLE: begin
                // A result pulse from the divider while idle is ignored.
                w_pop      = (r_count != '0) && !div_busy_in;
                w_issue    = w_pop && !w_head_zero;
                w_zero_res = w_pop && w_head_zero;
            end
            c_ST_WAIT: begin
                w_div_res  = div_valid_in;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs toward the divider and the result consumer.
    // All data outputs hold their values between pulses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_valid_out     <= 1'b0;
            div_dividend_out  <= '0;
            div_divisor_out   <= '0;
            r_tag             <= '0;
            res_valid_out     <= 1'b0;
            res_quotient_out  <= '0;
            res_remainder_out <= '0;
            res_tag_out       <= '0;
            res_error_out     <= 1'b0;
        end else begin
            div_valid_out <= w_issue;
            res_valid_out <= w_zero_res || w_div_res;

            if (w_issue) begin
                div_dividend_out <= w_head_dividend;
                div_divisor_out  <= w_head_divisor;
                r_tag            <= w_head_tag;
            end

            if (w_zero_res) begin
                // Divide-by-zero convention: all-ones quotient, dividend
                // passed through as the remainder.
                res_quotient_out  <= c_ALL_ONES;
                res_remainder_out <= w_head_dividend;
                res_tag_out       <= w_head_tag;
                res_error_out     <= 1'b1;
            end else if (w_div_res) begin
                res_quotient_out  <= div_quotient_in;
                res_remainder_out <= div_remainder_in;
                res_tag_out       <= r_tag;
                res_error_out     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_issue_queue
//  Description : Self-checking bench for div_issue_queue with a behavioural
//                multi-cycle divider attached to its handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_queue;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int LAT   = 10;   // divider latency in cycles
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk_in;
    logic             rst_in;
    logic             req_valid_in;
    logic             req_ready_out;
    logic [WIDTH-1:0] req_dividend_in;
    logic [WIDTH-1:0] req_divisor_in;
    logic [TAG_W-1:0] req_tag_in;
    logic [WIDTH-1:0] div_dividend_out;
    logic [WIDTH-1:0] div_divisor_out;
    logic             div_valid_out;
    logic             div_busy_in;
    logic             div_valid_in;
    logic [WIDTH-1:0] div_quotient_in;
    logic [WIDTH-1:0] div_remainder_in;
    logic             res_valid_out;
    logic [WIDTH-1:0] res_quotient_out;
    logic [WIDTH-1:0] res_remainder_out;
    logic [TAG_W-1:0] res_tag_out;
    logic             res_error_out;
    logic [CW-1:0]    count_out;

    div_issue_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .req_dividend_in  (req_dividend_in),
        .req_divisor_in   (req_divisor_in),
        .req_tag_in       (req_tag_in),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_valid_out    (div_valid_out),
        .div_busy_in      (div_busy_in),
        .div_valid_in     (div_valid_in),
        .div_quotient_in  (div_quotient_in),
        .div_remainder_in (div_remainder_in),
        .res_valid_out    (res_valid_out),
        .res_quotient_out (res_quotient_out),
        .res_remainder_out(res_remainder_out),
        .res_tag_out      (res_tag_out),
        .res_error_out    (res_error_out),
        .count_out        (count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ------------------------------------------------------------------------
    // Behavioural divider: accepts a start pulse when idle, answers LAT
    // cycles later with a one-cycle result pulse. Shares the reset.
    // ------------------------------------------------------------------------
    logic             m_busy;
    logic             m_valid;
    logic             sp_valid;      // spurious result pulse injected by bench
    int               m_cnt;
    logic [WIDTH-1:0] m_a, m_b, m_q, m_r;

    assign div_busy_in      = m_busy;
    assign div_valid_in     = m_valid | sp_valid;
    assign div_quotient_in  = m_q;
    assign div_remainder_in = m_r;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_q     <= '0;
            m_r     <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_q     <= m_a / m_b;
                    m_r     <= m_a % m_b;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (div_valid_out) begin
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_a    <= div_dividend_out;
                m_b    <= div_divisor_out;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } iss_t;

    res_t exp_q[$];
    iss_t iss_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Expected behaviour of one accepted request.
    task automatic sb_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [TAG_W-1:0] tag);
        res_t e;
        iss_t s;
        e.tag = tag;
        if (b == '0) begin
            e.q   = {WIDTH{1'b1}};
            e.r   = a;
            e.err = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.err = 1'b0;
            s.a   = a;
            s.b   = b;
            iss_q.push_back(s);
        end
        exp_q.push_back(e);
    endtask

    // Advance to the next falling edge and check any issue/result pulse.
    task automatic tick();
        res_t e;
        iss_t s;
        @(negedge clk_in);
        if (div_valid_out === 1'b1) begin
            chk("issue_pending", WIDTH'(iss_q.size() != 0), WIDTH'(1));
            chk("issue_divider_idle", WIDTH'(div_busy_in), WIDTH'(0));
            if (iss_q.size() != 0) begin
                s = iss_q.pop_front();
                chk("issue_dividend", div_dividend_out, s.a);
                chk("issue_divisor", div_divisor_out, s.b);
            end
        end
        if (res_valid_out === 1'b1) begin
            chk("res_pending", WIDTH'(exp_q.size() != 0), WIDTH'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_quotient", res_quotient_out, e.q);
                chk("res_remainder", res_remainder_out, e.r);
                chk("res_tag", WIDTH'(res_tag_out), WIDTH'(e.tag));
                chk("res_error", WIDTH'(res_error_out), WIDTH'(e.err));
            end
        end
    endtask

    // Hold a request until accepted (bounded); returns at the falling edge
    // after the accepting clock edge.
    task automatic push_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [TAG_W-1:0] tag, input int budget);
        bit ok;
        ok = 1'b0;
        req_valid_in    = 1'b1;
        req_dividend_in = a;
        req_divisor_in  = b;
        req_tag_in      = tag;
        for (int i = 0; i < budget && !ok; i++) begin
            if (req_ready_out) begin
                ok = 1'b1;
                sb_add(a, b, tag);
            end
            tick();
        end
        req_valid_in = 1'b0;
        chk("push_accepted", WIDTH'(ok), WIDTH'(1));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            tick();
        end
        chk("drain", WIDTH'(exp_q.size()), WIDTH'(0));
    endtask

    task automatic check_cleared(input string pfx);
        chk({pfx, "_count"}, WIDTH'(count_out), WIDTH'(0));
        chk({pfx, "_ready"}, WIDTH'(req_ready_out), WIDTH'(1));
        chk({pfx, "_div_valid"}, WIDTH'(div_valid_out), WIDTH'(0));
        chk({pfx, "_res_valid"}, WIDTH'(res_valid_out), WIDTH'(0));
        chk({pfx, "_res_error"}, WIDTH'(res_error_out), WIDTH'(0));
        chk({pfx, "_res_q"}, res_quotient_out, WIDTH'(0));
        chk({pfx, "_res_r"}, res_remainder_out, WIDTH'(0));
        chk({pfx, "_res_tag"}, WIDTH'(res_tag_out), WIDTH'(0));
        chk({pfx, "_div_a"}, div_dividend_out, WIDTH'(0));
        chk({pfx, "_div_b"}, div_divisor_out, WIDTH'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int seen;
        rst_in          = 1'b1;
        req_valid_in    = 1'b0;
        req_dividend_in = '0;
        req_divisor_in  = '0;
        req_tag_in      = '0;
        sp_valid        = 1'b0;

        // Reset state
        repeat (3) tick();
        check_cleared("reset");
        rst_in = 1'b0;
        tick();

        // 100 / 7, tag 3: visible one cycle after push, issued the next
        push_req(WIDTH'(100), WIDTH'(7), 4'd3, 4);
        chk("lat_no_issue_yet", WIDTH'(div_valid_out), WIDTH'(0));
        chk("lat_count_1", WIDTH'(count_out), WIDTH'(1));
        tick();
        chk("lat_issue", WIDTH'(div_valid_out), WIDTH'(1));
        chk("lat_count_0", WIDTH'(count_out), WIDTH'(0));
        tick();
        chk("issue_single_pulse", WIDTH'(div_valid_out), WIDTH'(0));
        wait_drain(LAT + 10);
        tick();
        chk("res_single_pulse", WIDTH'(res_valid_out), WIDTH'(0));
        chk("res_q_held", res_quotient_out, WIDTH'(14));

        // 55 / 0, tag 9: answered locally two cycles after the push
        push_req(WIDTH'(55), WIDTH'(0), 4'd9, 4);
        chk("dz_no_res_yet", WIDTH'(res_valid_out), WIDTH'(0));
        chk("dz_count_1", WIDTH'(count_out), WIDTH'(1));
        tick();
        chk("dz_res_valid", WIDTH'(res_valid_out), WIDTH'(1));
        chk("dz_no_issue", WIDTH'(div_valid_out), WIDTH'(0));
        tick();
        chk("dz_res_single_pulse", WIDTH'(res_valid_out), WIDTH'(0));
        chk("dz_error_held", WIDTH'(res_error_out), WIDTH'(1));

        // Fill the queue while a request occupies the divider
        push_req(WIDTH'(1000), WIDTH'(3), 4'd10, 4);
        tick();
        push_req(64'hFFFF_FFFF_FFFF_FFFF, WIDTH'(16), 4'd0, 2);
        push_req(WIDTH'(12345), WIDTH'(12345), 4'd1, 2);
        push_req(WIDTH'(77), WIDTH'(0), 4'd2, 2);
        push_req(WIDTH'(5), WIDTH'(9), 4'd3, 2);
        chk("full_count_4", WIDTH'(count_out), WIDTH'(4));
        chk("full_not_ready", WIDTH'(req_ready_out), WIDTH'(0));

        // Fifth request held high through the pop cycle: refused then, taken next
        req_valid_in    = 1'b1;
        req_dividend_in = 64'h8000_0000_0000_0001;
        req_divisor_in  = 64'h0000_0001_0000_0000;
        req_tag_in      = 4'd4;
        for (int i = 0; i < 4 * LAT && count_out == CW'(4); i++) begin
            tick();
        end
        chk("pop_count_3", WIDTH'(count_out), WIDTH'(3));
        chk("pop_ready", WIDTH'(req_ready_out), WIDTH'(1));
        if (req_ready_out) begin
            sb_add(req_dividend_in, req_divisor_in, req_tag_in);
        end
        tick();
        req_valid_in = 1'b0;
        chk("refill_count_4", WIDTH'(count_out), WIDTH'(4));
        wait_drain(8 * (LAT + 5));

        // Asynchronous reset mid-WAIT with two queued requests
        push_req(WIDTH'(20), WIDTH'(3), 4'd5, 4);
        tick();
        push_req(WIDTH'(1), WIDTH'(1), 4'd6, 2);
        push_req(WIDTH'(2), WIDTH'(1), 4'd7, 2);
        chk("pre_rst_count_2", WIDTH'(count_out), WIDTH'(2));
        #2 rst_in = 1'b1;
        #1 check_cleared("async_rst");
        exp_q.delete();
        iss_q.delete();
        tick();
        tick();
        rst_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            tick();
            if (res_valid_out === 1'b1) seen++;
        end
        chk("post_rst_no_result", WIDTH'(seen), WIDTH'(0));
        chk("post_rst_count", WIDTH'(count_out), WIDTH'(0));

        // Spurious divider result while idle and empty
        sp_valid = 1'b1;
        tick();
        sp_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (res_valid_out === 1'b1) seen++;
        end
        chk("spurious_no_result", WIDTH'(seen), WIDTH'(0));
        chk("spurious_count", WIDTH'(count_out), WIDTH'(0));
        // Still IDLE: a new request is issued and completes
        push_req(WIDTH'(9), WIDTH'(4), 4'd11, 4);
        wait_drain(LAT + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
